// File: rtl/alu_mc.sv
// Registered multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops finish in one edge; MUL iterates shift-add over WIDTH cycles.
module alu_mc #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_out,
   output logic             a_is_zero,
   output logic             zero,
   output logic             carry
);

   localparam logic [3:0] OP_ADD   = 4'd2;
   localparam logic [3:0] OP_AND   = 4'd3;
   localparam logic [3:0] OP_XOR   = 4'd4;
   localparam logic [3:0] OP_PASSB = 4'd5;
   localparam logic [3:0] OP_SUB   = 4'd8;
   localparam logic [3:0] OP_OR    = 4'd9;
   localparam logic [3:0] OP_SHL   = 4'd10;
   localparam logic [3:0] OP_SHR   = 4'd11;
   localparam logic [3:0] OP_MUL   = 4'd12;

   typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

   state_t             state_q;
   logic               out_valid_q;
   logic [WIDTH-1:0]   alu_out_q;
   logic               zero_q;
   logic               carry_q;
   logic               a_is_zero_q;

   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [SHW-1:0]     cnt_q;
   logic               mul_az_q;

   logic [WIDTH-1:0]   res_d;
   logic               carry_d;
   logic [WIDTH:0]     sum_w;
   logic [WIDTH:0]     diff_w;
   logic [WIDTH:0]     shl_w;
   logic [WIDTH:0]     shr_w;
   logic [SHW-1:0]     shamt;
   logic [2*WIDTH-1:0] acc_d;
   logic               accept;
   logic               mul_last;

   assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign alu_out   = alu_out_q;
   assign zero      = zero_q;
   assign carry     = carry_q;
   assign a_is_zero = a_is_zero_q;

   assign shamt    = in_b[SHW-1:0];
   assign mul_last = (cnt_q == SHW'(WIDTH - 1));
   assign acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

   // One guard bit on each shift catches the last bit pushed out of that end.
   always_comb begin
      sum_w   = {1'b0, in_a} + {1'b0, in_b};
      diff_w  = {1'b0, in_a} - {1'b0, in_b};
      shl_w   = {1'b0, in_a} << shamt;
      shr_w   = {in_a, 1'b0} >> shamt;
      res_d   = in_a;
      carry_d = 1'b0;
      case (opcode)
         OP_ADD:   begin res_d = sum_w[WIDTH-1:0];  carry_d = sum_w[WIDTH];  end
         OP_AND:   res_d = in_a & in_b;
         OP_XOR:   res_d = in_a ^ in_b;
         OP_PASSB: res_d = in_b;
         OP_SUB:   begin res_d = diff_w[WIDTH-1:0]; carry_d = diff_w[WIDTH]; end
         OP_OR:    res_d = in_a | in_b;
         OP_SHL:   begin res_d = shl_w[WIDTH-1:0];  carry_d = shl_w[WIDTH];  end
         OP_SHR:   begin res_d = shr_w[WIDTH:1];    carry_d = shr_w[0];      end
         default:  res_d = in_a;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         alu_out_q   <= '0;
         zero_q      <= 1'b0;
         carry_q     <= 1'b0;
         a_is_zero_q <= 1'b0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         mul_az_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE, HOLD: begin
               if (accept) begin
                  if (opcode == OP_MUL) begin
                     mcand_q     <= {{WIDTH{1'b0}}, in_a};
                     mplier_q    <= in_b;
                     acc_q       <= '0;
                     cnt_q       <= '0;
                     mul_az_q    <= (in_a == '0);
                     out_valid_q <= 1'b0;
                     state_q     <= MUL;
                  end else begin
                     alu_out_q   <= res_d;
                     zero_q      <= (res_d == '0);
                     carry_q     <= carry_d;
                     a_is_zero_q <= (in_a == '0);
                     out_valid_q <= 1'b1;
                     state_q     <= HOLD;
                  end
               end else if ((state_q == HOLD) && out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            MUL: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + 1'b1;
               if (mul_last) begin
                  alu_out_q   <= acc_d[WIDTH-1:0];
                  zero_q      <= (acc_d[WIDTH-1:0] == '0);
                  carry_q     <= |acc_d[2*WIDTH-1:WIDTH];
                  a_is_zero_q <= mul_az_q;
                  out_valid_q <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= HOLD;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, registered, multi-cycle ALU for the RISC CPU datapath. Successor to the combinational 8-bit ALU.
- Keeps the existing 3-bit operation encoding (codes 0-7) and adds SUB, OR, variable shifts and an iterative multiply.
- Adds valid/ready handshakes on input and output, plus registered zero/carry flags.
- Sits between the operand registers/accumulator and the writeback mux. The controller stalls on in_ready/out_valid instead of fixed timing.

Parameters:
- WIDTH, 8, data width in bits; legal values are 2 to 64.
- SHW, $clog2(WIDTH), shift-amount width; derived, do not override.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation and operands presented.
- in_ready  output  1  ALU can accept an operation this cycle.
- opcode  input  4  operation select (see Behaviour).
- in_a  input  WIDTH  operand A (accumulator).
- in_b  input  WIDTH  operand B (memory/immediate).
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer takes the result this cycle.
- alu_out  output  WIDTH  registered result.
- a_is_zero  output  1  registered: captured in_a was zero.
- zero  output  1  registered: alu_out is zero.
- carry  output  1  registered: carry/borrow/overflow as defined per op.

Behaviour:
- Accept occurs on a rising edge where in_valid && in_ready. On accept, opcode, in_a and in_b are captured internally.
- Opcode encoding:
  - 0, 1, 6, 7: PASSA.
  - 2: ADD.
  - 3: AND.
  - 4: XOR.
  - 5: PASSB.
  - 8: SUB (a-b).
  - 9: OR.
  - 10: SHL (a << b[SHW-1:0]).
  - 11: SHR logical (a >> b[SHW-1:0]).
  - 12: MUL (low WIDTH bits of a*b, unsigned).
  - 13-15: PASSA.
- Codes 0-7 produce results bit-identical to the legacy ALU.
- Carry:
  - ADD: carry-out of the WIDTH+1-bit sum.
  - SUB: borrow, i.e. 1 iff a<b unsigned.
  - SHL: last bit shifted out of the MSB end. SHR: last bit shifted out of the LSB end. Shift amount 0 gives carry 0.
  - MUL: 1 iff the upper WIDTH product bits are nonzero.
  - All other ops: 0.
- zero = (alu_out==0).
- a_is_zero = (captured in_a==0). It is registered with the result, not combinational.
- FSM states: IDLE, MUL, HOLD.
  - IDLE: in_ready=1, out_valid=0.
    - On accept of a non-MUL op: compute, register result and flags, go to HOLD. out_valid is high in the cycle after the accept edge (latency 1).
    - On accept of MUL: load multiplicand, multiplier, clear accumulator and counter, go to MUL.
  - MUL: in_ready=0, out_valid=0.
    - One shift-add iteration per cycle.
    - After WIDTH iterations, register result and flags and go to HOLD.
    - out_valid rises after edge accept+WIDTH (latency WIDTH).
  - HOLD: out_valid=1. alu_out and flags are stable until the handshake completes.
    - in_ready = out_ready (combinational).
    - out_ready=0: stay in HOLD and hold all outputs.
    - out_ready=1 && !in_valid: go to IDLE.
    - out_ready=1 && in_valid, non-MUL op: the new result replaces the old one on the same edge and the block stays in HOLD. This gives back-to-back throughput of 1/cycle.
    - out_ready=1 && in_valid, MUL: go to MUL.
- in_ready is combinational from state and out_ready only. It never depends on in_valid.
- Arithmetic is unsigned and truncated to WIDTH bits. Extra bits are used only for carry.
- Reset (asynchronous, any state, including mid-MUL):
  - State goes to IDLE.
  - out_valid=0, alu_out=0, zero=0, carry=0, a_is_zero=0, iteration counter=0.
  - An in-flight operation is discarded and in_ready=1.
- in_valid while in MUL is ignored (not accepted); the input must be held by the source.
- Operand changes on in_a/in_b after accept have no effect on the in-flight operation.

Test Plan:
- WIDTH=8, legacy codes 0-7 with a=0x3C, b=0xA5, out_ready=1 → results: codes 0,1,6,7 give 0x3C; ADD 0xE1 (carry 0); AND 0x24; XOR 0x99; PASSB 0xA5. out_valid exactly 1 cycle after each accept. Back-to-back accepts every cycle with no bubbles.
- ADD a=0xFF, b=0x01 → alu_out=0x00, zero=1, carry=1. SUB a=0x05, b=0x07 → 0xFE, carry=1. SUB a=0, b=0 → zero=1, carry=0, a_is_zero=1.
- SHL a=0x81, b=3 → 0x08, carry=0 (last bit out is bit5=0). SHR a=0x81, b=1 → 0x40, carry=1. SHL with b=8 (amount 0) → 0x81, carry=0.
- MUL a=13, b=11 → in_ready low for 8 cycles, out_valid after edge accept+8, alu_out=0x8F, carry=0. MUL a=0x20, b=0x10 → 0x00, carry=1, zero=1.
- Backpressure: out_ready=0 for 5 cycles after a result → alu_out and flags stable, in_ready=0, new in_valid not accepted. Raising out_ready with in_valid high completes the transfer and accepts the next op on the same edge.
- Deassert rst_n at MUL iteration 4 → out_valid=0, alu_out=0, flags=0, in_ready=1 immediately (asynchronously). After release, a fresh ADD 2+3 returns 5 with latency 1.
